// File: rtl/param_serial_adder.sv
// Chunk-serial adder: CHUNK bits of a+b per cycle, valid/ready handshakes.
// Optional subtract mode when SERIAL_ADDER_SUB_EN is defined (adds port sub).
module param_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [CHUNK:0]   part;
  logic [WIDTH-1:0] b_in;
  logic             c_in;

  // Operand B and initial carry as captured (inverted B, carry 1 for subtract)
  always_comb begin
    b_in = b;
    c_in = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_in = ~b;
      c_in = 1'b1;
    end
`endif
  end

  // One chunk of the running addition
  always_comb begin
    part = {1'b0, opa[int'(cnt)*CHUNK +: CHUNK]}
         + {1'b0, opb[int'(cnt)*CHUNK +: CHUNK]}
         + {{CHUNK{1'b0}}, carry};
  end

  // Control FSM with registered handshake outputs and datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            opa      <= a;
            opb      <= b_in;
            carry    <= c_in;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          sum[int'(cnt)*CHUNK +: CHUNK] <= part[CHUNK-1:0];
          carry <= part[CHUNK];
          if (cnt == LAST) begin
            cnt       <= '0;
            cout      <= part[CHUNK];
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_serial_adder.sv
// Directed bench for param_serial_adder (CHUNK=4 and CHUNK=16 instances).
// Table vectors plus hand sequences for back-pressure, reset and sub mode.
module tb_param_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] a, b, sum;
  logic        cin, cout;
  logic        sub;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
  logic [15:0] a16, b16, sum16;
  logic        cin16, cout16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  param_serial_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(1'b0),
`endif
    .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .cout(cout16), .busy(busy16)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, scramble inputs while busy, check result and handoff
  task automatic run_op(input vec_t v, input string name);
    int n;
    a = v.a; b = v.b; cin = v.cin; sub = v.sub;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 16'(~v.a); b = 16'(v.b ^ 16'h5A5A); cin = ~v.cin; sub = ~v.sub;
    check({name, " busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({name, " latency"}, 32'(n), 32'd4);
    check({name, " sum"}, 32'(sum), 32'(v.sum));
    check({name, " cout"}, 32'(cout), 32'(v.cout));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, " idle"}, {30'd0, in_ready, out_valid}, 32'b10);
    check({name, " keep"}, {15'd0, cout, sum}, {15'd0, v.cout, v.sum});
  endtask

  initial begin
    int n;
    logic [15:0] hs;
    logic        hc;

    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
    in_valid16 = 1'b0; out_ready16 = 1'b0;
    a16 = '0; b16 = '0; cin16 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    check("reset state",
          {27'd0, in_ready, out_valid, busy, cout, 1'b0},
          {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    check("reset sum", 32'(sum), 32'd0);

    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0});
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0});
    vecs.push_back('{16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
    vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0});
    vecs.push_back('{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1});
`endif

    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i], $sformatf("vec%0d", i));

    // Back-pressure: result holds, new requests ignored, handoff blocks issue
    a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    tick();
    a = 16'h0101; b = 16'h0202;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("bp latency", 32'(n), 32'd4);
    hs = sum; hc = cout;
    check("bp sum", 32'(hs), 32'h5555);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp hold%0d", i),
            {13'd0, out_valid, in_ready, cout, sum},
            {13'd0, 1'b1, 1'b0, 1'b0, 16'h5555});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("bp handoff", {29'd0, in_ready, out_valid, busy}, 32'b100);

    // Reset in the second RUN cycle aborts the operation
    a = 16'h0001; b = 16'h0002; cin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort state", {29'd0, in_ready, out_valid, busy}, 32'b100);
    check("abort result", {15'd0, cout, sum}, 32'd0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) n++;
    end
    check("abort no valid", 32'(n), 32'd0);
    run_op('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0}, "post abort");

    // Single-chunk instance completes in one cycle
    a16 = 16'hA5A5; b16 = 16'h5A5A; cin16 = 1'b1;
    in_valid16 = 1'b1;
    tick();
    in_valid16 = 1'b0;
    n = 0;
    while (!out_valid16 && n < 20) begin
      tick();
      n++;
    end
    check("c16 latency", 32'(n), 32'd1);
    check("c16 result", {15'd0, cout16, sum16}, {15'd0, 1'b1, 16'h0000});
    out_ready16 = 1'b1;
    tick();
    out_ready16 = 1'b0;
    check("c16 idle", {30'd0, in_ready16, out_valid16}, 32'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
